// File: rtl/ps2_uart_pkg.sv
// Shared constants and types for the PS/2-to-UART mouse-report receiver.
package ps2_uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hAA;
  localparam int         PKT_LEN   = 6;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;

  typedef enum logic [2:0] {
    P_SYNC,
    P_XL,
    P_XH,
    P_YL,
    P_YH,
    P_BTN
  } parser_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Rounded clocks-per-bit so the sample point drifts as little as possible.
  function automatic int baud_div(input int freq_hz, input int baud);
    return (freq_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchroniser, baud counter and byte FSM.
module uart_rx_byte
  import ps2_uart_pkg::*;
#(
  parameter int FREQ_HZ = 27000000,
  parameter int BAUD    = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic       byte_stb,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       idle,
  output logic       start_det
);

  localparam int DIV   = baud_div(FREQ_HZ, BAUD);
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  logic rxd_meta, rxd_sync, rxd_prev;

  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             brk_wait, brk_wait_n;
  logic             stb_n, ferr_n;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign idle      = (state == RX_IDLE);
  assign start_det = idle && !brk_wait && rxd_prev && !rxd_sync;
  assign rx_byte   = shift;

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 1'b1;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    brk_wait_n = brk_wait;
    stb_n      = 1'b0;
    ferr_n     = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (brk_wait) begin
          if (rxd_sync) brk_wait_n = 1'b0;
        end else if (start_det) begin
          state_n = RX_START;
        end
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = 3'd0;
          state_n   = rxd_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == DIV_LAST) begin
          cnt_n     = '0;
          shift_n   = {rxd_sync, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
        if (cnt == DIV_LAST) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          if (rxd_sync) begin
            stb_n = 1'b1;
          end else begin
            ferr_n     = 1'b1;
            brk_wait_n = 1'b1;
          end
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      brk_wait  <= 1'b0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      brk_wait  <= brk_wait_n;
      byte_stb  <= stb_n;
      frame_err <= ferr_n;
    end
  end

endmodule

// File: rtl/ps2_uart_packet_rx.sv
// Mouse-report packet receiver: frames sync/X/Y/button bytes from the UART link.
module ps2_uart_packet_rx
  import ps2_uart_pkg::*;
#(
  parameter int FREQ_HZ      = 27000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic       pkt_valid,
  output logic [8:0] pos_x,
  output logic [8:0] pos_y,
  output logic [2:0] btn,
  output logic       frame_err,
  output logic       sync_err
);

  localparam int DIV    = baud_div(FREQ_HZ, BAUD);
  localparam int TO_CYC = TIMEOUT_BITS * DIV;
  localparam int TO_W   = $clog2(TO_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  logic       rx_stb, rx_ferr, rx_idle, rx_start;
  logic [7:0] rx_byte;

  uart_rx_byte #(
    .FREQ_HZ(FREQ_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rxd (uart_rxd),
    .byte_stb (rx_stb),
    .rx_byte  (rx_byte),
    .frame_err(rx_ferr),
    .idle     (rx_idle),
    .start_det(rx_start)
  );

  parser_state_t pstate, pstate_n;
  logic [8:0]    x_sh, x_sh_n, y_sh, y_sh_n;
  logic [8:0]    pos_x_n, pos_y_n;
  logic [2:0]    btn_n;
  logic          pkt_valid_n, sync_err_n;
  logic [TO_W-1:0] to_cnt, to_cnt_n;

  always_comb begin
    pstate_n    = pstate;
    x_sh_n      = x_sh;
    y_sh_n      = y_sh;
    pos_x_n     = pos_x;
    pos_y_n     = pos_y;
    btn_n       = btn;
    pkt_valid_n = 1'b0;
    sync_err_n  = 1'b0;
    to_cnt_n    = to_cnt;

    // A start edge in the expiry cycle clears the counter, so the timeout never fires then.
    if (pstate == P_SYNC || rx_start) begin
      to_cnt_n = '0;
    end else if (rx_idle && !rx_stb && !rx_ferr) begin
      if (to_cnt == TO_LAST) begin
        to_cnt_n   = '0;
        sync_err_n = 1'b1;
        pstate_n   = P_SYNC;
      end else begin
        to_cnt_n = to_cnt + 1'b1;
      end
    end

    if (rx_ferr && pstate != P_SYNC) begin
      sync_err_n = 1'b1;
      pstate_n   = P_SYNC;
    end

    if (rx_stb) begin
      case (pstate)
        P_SYNC: begin
          if (rx_byte == SYNC_BYTE) pstate_n = P_XL;
          else sync_err_n = 1'b1;
        end
        P_XL: begin
          x_sh_n[7:0] = rx_byte;
          pstate_n    = P_XH;
        end
        P_XH: begin
          if (rx_byte[7:1] == 7'd0) begin
            x_sh_n[8] = rx_byte[0];
            pstate_n  = P_YL;
          end else begin
            sync_err_n = 1'b1;
            pstate_n   = P_SYNC;
          end
        end
        P_YL: begin
          y_sh_n[7:0] = rx_byte;
          pstate_n    = P_YH;
        end
        P_YH: begin
          if (rx_byte[7:1] == 7'd0) begin
            y_sh_n[8] = rx_byte[0];
            pstate_n  = P_BTN;
          end else begin
            sync_err_n = 1'b1;
            pstate_n   = P_SYNC;
          end
        end
        P_BTN: begin
          pstate_n = P_SYNC;
          if (rx_byte[7:3] == 5'd0) begin
            pos_x_n      = x_sh;
            pos_y_n      = y_sh;
            btn_n[BTN_L] = rx_byte[BTN_L];
            btn_n[BTN_R] = rx_byte[BTN_R];
            btn_n[BTN_M] = rx_byte[BTN_M];
            pkt_valid_n  = 1'b1;
          end else begin
            sync_err_n = 1'b1;
          end
        end
        default: pstate_n = P_SYNC;
      endcase
    end
  end

  // frame_err is re-registered so it lines up with the sync_err it may trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate    <= P_SYNC;
      x_sh      <= 9'd0;
      y_sh      <= 9'd0;
      to_cnt    <= '0;
      pos_x     <= 9'd0;
      pos_y     <= 9'd0;
      btn       <= 3'd0;
      pkt_valid <= 1'b0;
      sync_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      pstate    <= pstate_n;
      x_sh      <= x_sh_n;
      y_sh      <= y_sh_n;
      to_cnt    <= to_cnt_n;
      pos_x     <= pos_x_n;
      pos_y     <= pos_y_n;
      btn       <= btn_n;
      pkt_valid <= pkt_valid_n;
      sync_err  <= sync_err_n;
      frame_err <= rx_ferr;
    end
  end

endmodule

// File: tb/tb_ps2_uart_packet_rx.sv
// Directed bench for ps2_uart_packet_rx with a byte-stream packet model and per-cycle compare.
module tb_ps2_uart_packet_rx;

  // A reduced clock keeps the run short; DIV still goes through the rounding formula (23).
  localparam int FREQ_HZ      = 2_700_000;
  localparam int BAUD         = 115_200;
  localparam int TIMEOUT_BITS = 30;
  localparam int DIV          = (FREQ_HZ + BAUD / 2) / BAUD;
  localparam int HALF         = DIV / 2;
  localparam int TO_CYC       = TIMEOUT_BITS * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       pkt_valid, frame_err, sync_err;
  logic [8:0] pos_x, pos_y;
  logic [2:0] btn;

  ps2_uart_packet_rx #(
    .FREQ_HZ     (FREQ_HZ),
    .BAUD        (BAUD),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rxd (uart_rxd),
    .pkt_valid(pkt_valid),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .btn      (btn),
    .frame_err(frame_err),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- packet model over the received byte stream ----------------
  typedef struct {
    int x;
    int y;
    int b;
  } pkt_t;

  pkt_t       exp_q[$];
  logic [7:0] m_buf[6];
  int         m_idx;
  int         cur_x, cur_y, cur_b;
  int         exp_serr = 0, exp_ferr = 0, exp_both = 0;
  int         obs_serr = 0, obs_ferr = 0, obs_both = 0;

  function automatic void model_byte(input logic [7:0] b);
    pkt_t p;
    case (m_idx)
      0: if (b == 8'hAA) m_idx = 1; else exp_serr++;
      1, 3: begin m_buf[m_idx] = b; m_idx++; end
      2, 4: begin
        if (b[7:1] == 7'd0) begin m_buf[m_idx] = b; m_idx++; end
        else begin exp_serr++; m_idx = 0; end
      end
      default: begin
        if (b[7:3] == 5'd0) begin
          p.x = int'(m_buf[1]) - (m_buf[2][0] ? 256 : 0);
          p.y = int'(m_buf[3]) - (m_buf[4][0] ? 256 : 0);
          p.b = int'(b[2:0]);
          exp_q.push_back(p);
        end else begin
          exp_serr++;
        end
        m_idx = 0;
      end
    endcase
  endfunction

  function automatic void model_ferr();
    exp_ferr++;
    if (m_idx != 0) begin
      exp_serr++;
      exp_both++;
      m_idx = 0;
    end
  endfunction

  function automatic void model_timeout();
    if (m_idx != 0) exp_serr++;
    m_idx = 0;
  endfunction

  function automatic void model_reset();
    m_idx = 0;
    exp_q.delete();
    cur_x = 0;
    cur_y = 0;
    cur_b = 0;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    pkt_t p;
    if (rst_n) begin
      if (sync_err) obs_serr++;
      if (frame_err) obs_ferr++;
      if (sync_err && frame_err) obs_both++;
      if (pkt_valid) begin
        check("pkt_with_sync_err", int'(sync_err), 0);
        check("pkt_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          p = exp_q.pop_front();
          cur_x = p.x;
          cur_y = p.y;
          cur_b = p.b;
        end
      end
      check("pos_x", int'($signed(pos_x)), cur_x);
      check("pos_y", int'($signed(pos_y)), cur_y);
      check("btn", int'(btn), cur_b);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_bits(input int n);
    repeat (n * DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) model_byte(b);
    else model_ferr();
    uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rxd = stop_ok;
    repeat (DIV) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic send_pkt(input logic [47:0] bytes);
    for (int i = 0; i < 6; i++) send_byte(bytes[47-8*i -: 8], 1'b1);
  endtask

  task automatic end_scenario(input string tag);
    wait_bits(3);
    check({tag, "_sync_err_count"}, obs_serr, exp_serr);
    check({tag, "_frame_err_count"}, obs_ferr, exp_ferr);
    check({tag, "_both_err_count"}, obs_both, exp_both);
    check({tag, "_pkts_missing"}, exp_q.size(), 0);
  endtask

  task automatic expect_pkt(input string tag, input int x, input int y, input int b);
    check({tag, "_x"}, int'($signed(pos_x)), x);
    check({tag, "_y"}, int'($signed(pos_y)), y);
    check({tag, "_btn"}, int'(btn), b);
    check({tag, "_model_x"}, cur_x, x);
    check({tag, "_model_y"}, cur_y, y);
    check({tag, "_model_btn"}, cur_b, b);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pos_x"}, int'(pos_x), 0);
    check({tag, "_pos_y"}, int'(pos_y), 0);
    check({tag, "_btn"}, int'(btn), 0);
    check({tag, "_pkt_valid"}, int'(pkt_valid), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_sync_err"}, int'(sync_err), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int t0, base, elapsed;
    model_reset();
    repeat (5) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    wait_bits(2);

    // Short low glitch must not start a byte.
    uart_rxd = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    uart_rxd = 1'b1;
    wait_bits(2);
    end_scenario("glitch");

    send_pkt(48'hAA_0A_00_00_00_00);
    end_scenario("t1");
    expect_pkt("t1", 10, 0, 0);

    send_pkt(48'hAA_EC_01_F8_01_07);
    end_scenario("t2");
    expect_pkt("t2", -20, -8, 7);

    send_pkt(48'hAA_AA_00_7F_00_02);
    end_scenario("t3");
    expect_pkt("t3", 170, 127, 2);

    send_byte(8'h55, 1'b1);
    send_pkt(48'hAA_05_00_00_00_01);
    end_scenario("t4");
    expect_pkt("t4", 5, 0, 1);
    check("t4_one_sync_err", exp_serr, 1);

    send_byte(8'hAA, 1'b1);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h00, 1'b0);
    wait_bits(2);
    end_scenario("t5_ferr");
    check("t5_model_both", exp_both, 1);
    send_pkt(48'hAA_01_00_01_00_00);
    end_scenario("t5_after");
    expect_pkt("t5", 1, 1, 0);

    send_byte(8'hAA, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h02, 1'b1);
    end_scenario("xh_bad");

    send_byte(8'hAA, 1'b1);
    send_byte(8'h0A, 1'b1);
    t0 = cyc;
    base = obs_serr;
    for (int i = 0; i < TO_CYC + 4 * DIV; i++) begin
      @(negedge clk);
      if (obs_serr > base) break;
    end
    elapsed = cyc - t0;
    check("timeout_fired", int'(obs_serr > base), 1);
    check("timeout_delay", (elapsed >= TO_CYC - DIV && elapsed <= TO_CYC + DIV) ? TO_CYC : elapsed,
          TO_CYC);
    model_timeout();
    end_scenario("t6");

    send_byte(8'hAA, 1'b1);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h00, 1'b1);
    uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs_zero("mid_reset");
    rst_n = 1'b1;
    wait_bits(2);
    end_scenario("t7_reset");

    send_pkt(48'hAA_03_00_FD_01_04);
    end_scenario("t8");
    expect_pkt("t8", 3, -3, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
